// File: rtl/traffic_phase_timer_if.sv
// Control and observation bundle between the traffic light controller FSM and
// its phase timer: restart/hold/config strobes in, phase-expiry flags out.
interface traffic_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             hold;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic             tMG;
  logic             tMY;
  logic             tSG;
  logic             tSY;
  logic [CNT_W-1:0] elapsed;

  modport master (
    output start, hold, cfg_we, cfg_sel, cfg_data,
    input  tMG, tMY, tSG, tSY, elapsed
  );

  modport slave (
    input  start, hold, cfg_we, cfg_sel, cfg_data,
    output tMG, tMY, tSG, tSY, elapsed
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic light controller: counts prescaled ticks since the
// last start and raises a level flag once each phase's active duration is reached.
module traffic_phase_timer #(
  parameter int PRESCALE = 50,
  parameter int CNT_W    = 8,
  parameter int MG_TIME  = 20,
  parameter int MY_TIME  = 4,
  parameter int SG_TIME  = 10,
  parameter int SY_TIME  = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  traffic_phase_timer_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_MG = 2'd0,
    SEL_MY = 2'd1,
    SEL_SG = 2'd2,
    SEL_SY = 2'd3
  } sel_e;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DEF_TIME [4] = '{
    CNT_W'(MG_TIME), CNT_W'(MY_TIME), CNT_W'(SG_TIME), CNT_W'(SY_TIME)
  };

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] pend [4];
  logic [CNT_W-1:0] act  [4];

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would let act see a same-edge pend write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      elapsed <= '0;
      // NOTE: the duration tables are only eight small registers and must come
      // up at their defaults, so they are reset explicitly rather than left as RAM.
      for (int i = 0; i < 4; i++) begin
        pend[i] <= DEF_TIME[i];
        act[i]  <= DEF_TIME[i];
      end
    end else begin
      if (bus.cfg_we) begin
        pend[bus.cfg_sel] <= bus.cfg_data;
      end

      if (bus.start) begin
        presc   <= '0;
        elapsed <= '0;
        // A write landing on the start edge bypasses pend so it is not lost for this phase.
        for (int i = 0; i < 4; i++) begin
          act[i] <= (bus.cfg_we && (bus.cfg_sel == 2'(i))) ? bus.cfg_data : pend[i];
        end
      end else if (!bus.hold) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          if (elapsed != CNT_MAX) begin
            elapsed <= elapsed + 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign bus.elapsed = elapsed;
  assign bus.tMG     = (elapsed >= act[SEL_MG]);
  assign bus.tMY     = (elapsed >= act[SEL_MY]);
  assign bus.tSG     = (elapsed >= act[SEL_SG]);
  assign bus.tSY     = (elapsed >= act[SEL_SY]);

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: a reference model pushes expected
// elapsed/flags per edge into a scoreboard, popped and compared after each edge.
module tb_traffic_phase_timer;

  localparam int P     = 4;
  localparam int CNT_W = 8;
  localparam int MG    = 5;
  localparam int MY    = 2;
  localparam int SG    = 3;
  localparam int SY    = 2;

  typedef struct packed {
    logic [CNT_W-1:0] elapsed;
    logic [3:0]       flags;   // {tSY, tSG, tMY, tMG}
  } obs_t;

  logic clk;
  logic reset_n;

  traffic_phase_timer_if #(.CNT_W(CNT_W)) bus ();

  traffic_phase_timer #(
    .PRESCALE (P),
    .CNT_W    (CNT_W),
    .MG_TIME  (MG),
    .MY_TIME  (MY),
    .SG_TIME  (SG),
    .SY_TIME  (SY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  obs_t sb [$];
  int   rise [4];

  // Reference model state
  int m_presc;
  int m_elapsed;
  int m_pend [4];
  int m_act  [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_presc   = 0;
    m_elapsed = 0;
    m_pend    = '{MG, MY, SG, SY};
    m_act     = '{MG, MY, SG, SY};
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.elapsed = CNT_W'(m_elapsed);
    for (int i = 0; i < 4; i++) o.flags[i] = (m_elapsed >= m_act[i]);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.elapsed = bus.elapsed;
    o.flags   = {bus.tSY, bus.tSG, bus.tMY, bus.tMG};
    return o;
  endfunction

  // Advance the model for the inputs now applied, then clock the DUT and compare.
  task automatic tick();
    obs_t e;
    if (bus.start) begin
      m_presc   = 0;
      m_elapsed = 0;
      for (int i = 0; i < 4; i++)
        m_act[i] = (bus.cfg_we && bus.cfg_sel == 2'(i)) ? int'(bus.cfg_data) : m_pend[i];
    end else if (!bus.hold) begin
      if (m_presc == P - 1) begin
        m_presc = 0;
        if (m_elapsed < 255) m_elapsed++;
      end else begin
        m_presc++;
      end
    end
    if (bus.cfg_we) m_pend[bus.cfg_sel] = int'(bus.cfg_data);
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("edge_obs", 32'(dut_obs()), 32'(e));
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [CNT_W-1:0] data, input logic with_start);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_data = data;
    bus.start    = with_start;
    tick();
    bus.cfg_we   = 1'b0;
    bus.start    = 1'b0;
  endtask

  // Count edges until each flag first rises; hold is asserted on edges (from, from+len].
  task automatic measure(input int budget, input int hold_from, input int hold_len);
    logic [3:0] f;
    for (int i = 0; i < 4; i++) rise[i] = -1;
    for (int n = 1; n <= budget; n++) begin
      bus.hold = (n > hold_from) && (n <= hold_from + hold_len);
      tick();
      f = {bus.tSY, bus.tSG, bus.tMY, bus.tMG};
      for (int i = 0; i < 4; i++)
        if (rise[i] < 0 && f[i]) rise[i] = n;
      if (rise[0] >= 0 && rise[1] >= 0 && rise[2] >= 0 && rise[3] >= 0) break;
    end
    bus.hold = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.hold     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 2'd0;
    bus.cfg_data = '0;
    reset_n      = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("reset_elapsed", 32'(bus.elapsed), 32'd0);
    check("reset_flags", 32'({bus.tSY, bus.tSG, bus.tMY, bus.tMG}), 32'd0);
    reset_n = 1'b1;

    // 1: flag rise times from a start
    start_pulse();
    measure(40, 0, 0);
    check("rise_mg", 32'(rise[0]), 32'd20);
    check("rise_my", 32'(rise[1]), 32'd8);
    check("rise_sg", 32'(rise[2]), 32'd12);
    check("rise_sy", 32'(rise[3]), 32'd8);

    // 2: restart mid-phase clears count and flags
    start_pulse();
    repeat (10) tick();
    start_pulse();
    check("restart_elapsed", 32'(bus.elapsed), 32'd0);
    check("restart_flags", 32'({bus.tSY, bus.tSG, bus.tMY, bus.tMG}), 32'd0);
    measure(40, 0, 0);
    check("restart_rise_mg", 32'(rise[0]), 32'd20);

    // 3: hold for 7 edges delays tMG by 7
    start_pulse();
    measure(60, 6, 7);
    check("hold_rise_mg", 32'(rise[0]), 32'd27);

    // 4: config write mid-phase applies only at next start
    start_pulse();
    repeat (3) tick();
    cfg_write(2'd0, 8'd9, 1'b0);
    measure(40, 0, 0);
    check("cfg_mid_rise_mg", 32'(rise[0] + 4), 32'd20);
    start_pulse();
    measure(60, 0, 0);
    check("cfg_next_rise_mg", 32'(rise[0]), 32'd36);
    cfg_write(2'd0, 8'd2, 1'b0);
    cfg_write(2'd0, 8'd9, 1'b1);
    measure(60, 0, 0);
    check("cfg_same_rise_mg", 32'(rise[0]), 32'd36);

    // 5: saturation
    start_pulse();
    repeat (255 * P + 8) tick();
    check("sat_elapsed", 32'(bus.elapsed), 32'd255);
    check("sat_flags", 32'({bus.tSY, bus.tSG, bus.tMY, bus.tMG}), 32'hF);

    // 6: asynchronous reset mid-phase, runtime config lost
    start_pulse();
    repeat (50) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_elapsed", 32'(bus.elapsed), 32'd0);
    check("async_flags", 32'({bus.tSY, bus.tSG, bus.tMY, bus.tMG}), 32'd0);
    #2;
    reset_n = 1'b1;
    start_pulse();
    measure(40, 0, 0);
    check("post_reset_rise_mg", 32'(rise[0]), 32'd20);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
